// File: rtl/dmem_pkg.sv
// Shared types and helpers for the pipelined data memory (data_mem_pipe).
package dmem_pkg;

  localparam logic [1:0] MEM_NOP = 2'b00;
  localparam logic [1:0] MEM_WR  = 2'b01;
  localparam logic [1:0] MEM_RD  = 2'b10;
  localparam logic [1:0] MEM_RW  = 2'b11;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Ceiling log2 for elaboration-time sizing; n is at least 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < 32'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_lat_pipe.sv
// Fixed-latency delay line with synchronous flush. When HOLD is set the MSB is a
// valid bit and the payload bits of each stage keep their value on bubbles.
module dmem_lat_pipe #(
  parameter int LAT  = 1,
  parameter int W    = 33,
  parameter bit HOLD = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] d_out
);

  logic [W-1:0] stg_r [LAT];
  logic [W-1:0] nxt_s [LAT];

  // Input of each stage: the pipe input or the previous stage
  always_comb begin
    nxt_s[0] = d_in;
    for (int k = 1; k < LAT; k++) begin
      nxt_s[k] = stg_r[k-1];
    end
  end

  // Advance all stages; bubbles only clear the valid bit in HOLD mode
  always_ff @(posedge clk) begin
    for (int k = 0; k < LAT; k++) begin
      if (rst) begin
        stg_r[k] <= '0;
      end else if (!HOLD || nxt_s[k][W-1]) begin
        stg_r[k] <= nxt_s[k];
      end else begin
        stg_r[k][W-1] <= 1'b0;
      end
    end
  end

  assign d_out = stg_r[LAT-1];

endmodule

// File: rtl/data_mem_pipe.sv
// Pipelined, byte-masked data memory with a post-reset clear sweep.
// Optional out-of-range flagging on rsp_err when DMEM_ERR_EN is defined.
module data_mem_pipe
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          mem_op,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rdata,
`ifdef DMEM_ERR_EN
  output logic                rsp_err,
`endif
  output logic                busy
);

  localparam int IDX_W = clog2(DEPTH);
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem_r [DEPTH];
  state_t            state_r, state_nxt_s;
  logic [IDX_W-1:0]  clr_cnt_r, clr_cnt_nxt_s;
  logic              req_ready_r, busy_r;
  logic              acc_s, op_rd_s, op_wr_s, oor_s;
  logic [IDX_W-1:0]  idx_s;
  logic [DATA_W-1:0] rd_data_s;
  logic [DATA_W:0]   rsp_s;

  assign idx_s = addr[IDX_W-1:0];
  assign acc_s = req_valid & req_ready_r & ~rst;

`ifdef DMEM_ERR_EN
  assign oor_s = |addr[ADDR_W-1:IDX_W];
`else
  logic unused_addr_hi_s;
  assign unused_addr_hi_s = ^addr[ADDR_W-1:IDX_W];
  assign oor_s = 1'b0;
`endif

  // Decode the request operation
  always_comb begin
    op_rd_s = 1'b0;
    op_wr_s = 1'b0;
    case (mem_op)
      MEM_NOP: begin
        op_rd_s = 1'b0;
        op_wr_s = 1'b0;
      end
      MEM_WR:  op_wr_s = 1'b1;
      MEM_RD:  op_rd_s = 1'b1;
      MEM_RW: begin
        op_rd_s = 1'b1;
        op_wr_s = 1'b1;
      end
      default: begin
        op_rd_s = 1'b0;
        op_wr_s = 1'b0;
      end
    endcase
  end

  // Clear-sweep FSM next state
  always_comb begin
    state_nxt_s   = state_r;
    clr_cnt_nxt_s = clr_cnt_r;
    case (state_r)
      CLEAR: begin
        clr_cnt_nxt_s = clr_cnt_r + IDX_W'(1);
        if (clr_cnt_r == IDX_W'(DEPTH - 1)) begin
          state_nxt_s = READY;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      READY:   state_nxt_s = READY;
      default: state_nxt_s = CLEAR;
    endcase
  end

  // FSM state and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= CLEAR;
      clr_cnt_r   <= '0;
      req_ready_r <= 1'b0;
      busy_r      <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      clr_cnt_r   <= clr_cnt_nxt_s;
      req_ready_r <= (state_nxt_s == READY);
      busy_r      <= (state_nxt_s == CLEAR);
    end
  end

  // Storage: sweep writes zeros, otherwise byte-masked request writes
  always_ff @(posedge clk) begin
    if (state_r == CLEAR) begin
      mem_r[clr_cnt_r] <= '0;
    end else if (acc_s && op_wr_s && !oor_s) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem_r[idx_s][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Sampled on the accept edge, so a combined read/write returns the old word
  assign rd_data_s = oor_s ? '0 : mem_r[idx_s];

  dmem_lat_pipe #(.LAT(RD_LAT), .W(DATA_W + 1), .HOLD(1'b1)) u_rsp_pipe (
    .clk   (clk),
    .rst   (rst),
    .d_in  ({acc_s & op_rd_s, rd_data_s}),
    .d_out (rsp_s)
  );

`ifdef DMEM_ERR_EN
  dmem_lat_pipe #(.LAT(RD_LAT), .W(1), .HOLD(1'b0)) u_err_pipe (
    .clk   (clk),
    .rst   (rst),
    .d_in  (acc_s & oor_s),
    .d_out (rsp_err)
  );
`endif

  assign rsp_valid = rsp_s[DATA_W];
  assign rdata     = rsp_s[DATA_W-1:0];
  assign req_ready = req_ready_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_data_mem_pipe.sv
// Directed self-checking bench for data_mem_pipe (DEPTH=16, RD_LAT=3).
module tb_data_mem_pipe;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 16;
  localparam int LAT   = 3;

  typedef struct {
    logic        vld;
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    mem_op = 2'b00;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    be = 4'h0;
  logic          rsp_valid;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          err_s;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t q[$];

  data_mem_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .mem_op    (mem_op),
    .addr      (addr),
    .wdata     (wdata),
    .be        (be),
    .rsp_valid (rsp_valid),
    .rdata     (rdata),
`ifdef DMEM_ERR_EN
    .rsp_err   (err_s),
`endif
    .busy      (busy)
  );

`ifndef DMEM_ERR_EN
  assign err_s = 1'b0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Response scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    if (rsp_valid || err_s) begin
      if (q.size() == 0) begin
        check("spurious_rsp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rsp_valid", 64'(rsp_valid), 64'(e.vld));
        check("rsp_err", 64'(err_s), 64'(e.err));
        check("rsp_cycle", 64'(cyc), 64'(e.cyc));
        if (e.vld) check("rdata", 64'(rdata), 64'(e.data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    mem_op    = 2'b00;
    repeat (n) step();
  endtask

  task automatic req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] b, input logic [31:0] exp, input logic flag);
    exp_t e;
    req_valid = 1'b1;
    mem_op    = op;
    addr      = a;
    wdata     = wd;
    be        = b;
    if (op[1] || flag) begin
      e.vld  = op[1];
      e.err  = flag;
      e.data = exp;
      e.cyc  = cyc + LAT;
      q.push_back(e);
    end
    step();
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    mem_op    = 2'b00;
    rst       = 1'b1;
    q.delete();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    check({tag, "_busy_start"}, 64'(busy), 64'd1);
    while (!req_ready && n < 100) begin
      step();
      n++;
    end
    check({tag, "_len"}, 64'(n), 64'(DEPTH));
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    step();
    do_reset();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    wait_clear("clear1");

    for (int k = 0; k < DEPTH; k++) req(2'b10, 32'(k), 32'h0, 4'h0, 32'h0, 1'b0);
    idle(LAT + 2);

    // Byte-masked write
    req(2'b01, 32'd3, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0);
    req(2'b01, 32'd3, 32'h0000_0011, 4'b0001, 32'h0, 1'b0);
    req(2'b10, 32'd3, 32'h0, 4'h0, 32'hDEAD_BE11, 1'b0);
    req(2'b01, 32'd3, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
    req(2'b10, 32'd3, 32'h0, 4'h0, 32'hDEAD_BE11, 1'b0);
    idle(LAT + 2);

    // Back-to-back stream
    for (int k = 0; k < 8; k++) req(2'b01, 32'(k), 32'h100 + 32'(k), 4'hF, 32'h0, 1'b0);
    for (int k = 0; k < 8; k++) req(2'b10, 32'(k), 32'h0, 4'h0, 32'h100 + 32'(k), 1'b0);
    idle(LAT + 3);
    check("hold_valid", 64'(rsp_valid), 64'd0);
    check("hold_rdata", 64'(rdata), 64'h107);

    // Read-before-write, then immediate read sees the new word
    req(2'b01, 32'd5, 32'hAAAA_0000, 4'hF, 32'h0, 1'b0);
    req(2'b11, 32'd5, 32'h5555_FFFF, 4'hF, 32'hAAAA_0000, 1'b0);
    req(2'b10, 32'd5, 32'h0, 4'h0, 32'h5555_FFFF, 1'b0);
    idle(LAT + 2);

`ifndef DMEM_ERR_EN
    // High address bits wrap
    req(2'b01, 32'h0000_0016, 32'h0000_0066, 4'hF, 32'h0, 1'b0);
    req(2'b10, 32'h0000_0006, 32'h0, 4'h0, 32'h0000_0066, 1'b0);
    req(2'b10, 32'hF000_0036, 32'h0, 4'h0, 32'h0000_0066, 1'b0);
    idle(LAT + 2);
`endif

    // Reset with reads in flight, then again at clear cycle 7
    req(2'b10, 32'd2, 32'h0, 4'h0, 32'h0000_0102, 1'b0);
    req(2'b10, 32'd2, 32'h0, 4'h0, 32'h0000_0102, 1'b0);
    do_reset();
    repeat (7) step();
    do_reset();
    wait_clear("clear2");
    for (int k = 0; k < DEPTH; k++) req(2'b10, 32'(k), 32'h0, 4'h0, 32'h0, 1'b0);
    idle(LAT + 2);

`ifdef DMEM_ERR_EN
    // Out-of-range access is flagged and suppressed
    req(2'b01, 32'h0, 32'hCAFE_0000, 4'hF, 32'h0, 1'b0);
    req(2'b01, 32'h10, 32'h1234_5678, 4'hF, 32'h0, 1'b1);
    req(2'b10, 32'h10, 32'h0, 4'h0, 32'h0, 1'b1);
    req(2'b10, 32'h0, 32'h0, 4'h0, 32'hCAFE_0000, 1'b0);
    idle(LAT + 2);
`endif

    check("pending_rsp", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
